pb_conditioner: RTL
===================

PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-input cycles required to accept a press or release (5 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter PB_ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed, 0 = raw key reads 1 when pressed.
REQ-003 Parameter REPEAT_DELAY, default 25000000, cycles held before the first auto-repeat pulse (used only with PB_AUTOREPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between auto-repeat pulses (used only with PB_AUTOREPEAT_EN).
REQ-005 CLK_50  input  1  system clock, 50 MHz, single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key_up_raw  input  1  asynchronous raw pushbutton, frequency-up request.
REQ-008 key_dn_raw  input  1  asynchronous raw pushbutton, frequency-down request.
REQ-009 pb_freq_up  output  1  one-cycle registered pulse per accepted up press, drives throttle pb_freq_up.
REQ-010 pb_freq_dn  output  1  one-cycle registered pulse per accepted down press, drives throttle pb_freq_dn.
REQ-011 key_state  output  2  registered debounced level {dn,up}, 1 = pressed.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer, then be polarity-normalised per PB_ACTIVE_LOW (pressed = 1).
REQ-013 Each channel SHALL run an independent FSM: IDLE, DEB_PRESS, HELD, DEB_RELEASE, with a 20-bit stability counter.
REQ-014 IDLE: counter 0; synced pressed -> DEB_PRESS.
REQ-015 DEB_PRESS: counter increments each cycle while pressed; released -> IDLE with counter cleared; counter reaching DEBOUNCE_CYCLES-1 while pressed -> HELD.
REQ-016 On the IDLE->...->HELD entry the channel SHALL assert its pulse for exactly one cycle, the cycle after the transition into HELD.
REQ-017 With raw input clean and stable, pulse SHALL appear DEBOUNCE_CYCLES+3 cycles after the first clock edge sampling pressed raw.
REQ-018 HELD: released -> DEB_RELEASE, counter cleared; no further pulses except per REQ-026.
REQ-019 DEB_RELEASE: counter increments while released; pressed -> HELD (no pulse); counter reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-020 key_state bit SHALL be 1 in HELD and DEB_RELEASE, 0 otherwise.
REQ-021 Counters SHALL saturate, never wrap.
REQ-022 Simultaneous events: if both channels would pulse in the same cycle, both pulses SHALL be suppressed; FSMs still advance to HELD.
REQ-023 A pulse pending from one channel SHALL never be delayed by the other channel's state.

Reset
REQ-024 reset high at a rising CLK_50 SHALL force both FSMs to IDLE, counters 0, synchronizer flops to the unpressed level, pb_freq_up=0, pb_freq_dn=0, key_state=2'b00 on that edge.
REQ-025 Reset mid-debounce or mid-hold SHALL discard progress; a key still held after reset deasserts SHALL be treated as a new press (full debounce, one pulse).

Configuration
REQ-026 Macro PB_AUTOREPEAT_EN defined: in HELD, after REPEAT_DELAY cycles since the initial pulse, channel SHALL emit one-cycle pulses every REPEAT_PERIOD cycles until leaving HELD; REQ-022 suppression applies to repeats.
REQ-027 Macro PB_AUTOREPEAT_EN undefined: exactly one pulse per accepted press; repeat counters and parameters SHALL have no hardware.

Verification (DEBOUNCE_CYCLES=4, PB_ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 reset 2 cycles, key_up_raw=0 held 50 cycles -> single pb_freq_up pulse at cycle 7 after first sampled 0; pb_freq_dn stays 0; key_state=2'b01.
REQ-029 key_dn_raw toggles every 2 cycles for 40 cycles then released -> no pb_freq_dn pulse, key_state[1] stays 0.
REQ-030 Both raw keys driven 0 on the same edge, held 30 cycles -> no pulses on either output, key_state=2'b11.
REQ-031 key_up_raw pressed, reset asserted 1 cycle during DEB_PRESS (counter=2), key held -> pulse occurs DEBOUNCE_CYCLES+3 cycles after reset release, exactly once.
REQ-032 Release bounce: held key bounces 1 for 2 cycles then returns 0 -> no second pulse, key_state remains 1.
REQ-033 With PB_AUTOREPEAT_EN, key_up_raw held 60 cycles -> pulses at initial, +20, +28, +36, +44, +52 cycles; without macro -> one pulse only.

Source files
------------

// File: rtl/pb_conditioner.sv
// pb_conditioner: two-channel pushbutton debouncer that emits one-cycle press pulses and debounced levels.
// Defining PB_AUTOREPEAT_EN adds auto-repeat pulses while a key stays held.

module pb_channel #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PB_ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  output logic       evt,
  output logic       level,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  localparam logic        IDLE_RAW = (PB_ACTIVE_LOW != 0);
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        sync1, sync2, pressed;
  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d, cnt_inc;
  logic        accept, rpt_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ IDLE_RAW;
  assign cnt_inc = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pressed) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_phase;

  // rpt_cnt counts HELD cycles since entry or since the last repeat; phase selects first delay vs period.
  assign rpt_fire = (state_q == HELD) && pressed &&
                    (rpt_cnt == (rpt_phase ? RPT_NEXT : RPT_FIRST));

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (state_d == HELD && state_q != HELD) begin
      rpt_cnt   <= RW'(1);
      rpt_phase <= 1'b0;
    end else if (state_q == HELD && pressed) begin
      if (rpt_fire) begin
        rpt_cnt   <= RW'(1);
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end
    end
  end
`else
  // Repeat parameters have no hardware here; this expression folds to 0.
  assign rpt_fire = (REPEAT_DELAY < 0) || (REPEAT_PERIOD < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level   <= 1'b0;
      evt     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= state_d[1];
      evt     <= accept | rpt_fire;
    end
  end

  assign state = state_q;
endmodule

module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PB_ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       key_up_raw,
  input  logic       key_dn_raw,
  output logic       pb_freq_up,
  output logic       pb_freq_dn,
  output logic [1:0] key_state,
  output logic [3:0] dbg_state
);
  logic up_evt, dn_evt, up_level, dn_level;
  logic [1:0] up_state, dn_state;

  pb_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PB_ACTIVE_LOW(PB_ACTIVE_LOW),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clk(CLK_50), .reset(reset), .key_raw(key_up_raw),
    .evt(up_evt), .level(up_level), .state(up_state)
  );

  pb_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .PB_ACTIVE_LOW(PB_ACTIVE_LOW),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .clk(CLK_50), .reset(reset), .key_raw(key_dn_raw),
    .evt(dn_evt), .level(dn_level), .state(dn_state)
  );

  // Coincident events cancel each other; a lone event is never held back by the other channel.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      pb_freq_up <= 1'b0;
      pb_freq_dn <= 1'b0;
    end else begin
      pb_freq_up <= up_evt & ~dn_evt;
      pb_freq_dn <= dn_evt & ~up_evt;
    end
  end

  assign key_state = {dn_level, up_level};
  assign dbg_state = {dn_state, up_state};
endmodule
